wrapper: RTL and testbench
==========================

WRAPPER -- requirements
Module: wrapper

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 0, idle cycles between packet bytes before a partial packet is discarded; 0 disables the timeout.
REQ-002 CLK  in  1  single clock; all logic on rising edge.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 DIP  in  16  unused.
REQ-005 PB  in  3  unused.
REQ-006 UART_RX  in  8  received byte.
REQ-007 UART_RX_valid  in  1  UART_RX holds a new byte.
REQ-008 UART_RX_ack  out  1  byte-capture acknowledge.
REQ-009 UART_TX  out  8  transmit byte.
REQ-010 UART_TX_valid  out  1  UART_TX valid.
REQ-011 UART_TX_ready  in  1  sink accepts UART_TX.
REQ-012 LED_OUT  out  8  {busy, error, 2'b0, byte_count[3:0]}.
REQ-013 LED_PC  out  7  last command byte [6:0].
REQ-014 SEVENSEGHEX  out  32  ComputeResult.
REQ-015 OLED_Write/OLED_Col/OLED_Row/OLED_Data  out  1/7/6/24  tied to 0.
REQ-016 ACCEL_Data  in  32, ACCEL_DReady  in  1  unused.

Function
REQ-017 Packet is 9 bytes: cmd, op1[31:24..7:0], op2[31:24..7:0], MSB first.
REQ-018 Receive handshake: in RX state with valid=1 and ack=0, capture UART_RX and set ack next cycle; hold ack while valid=1; clear ack the cycle after valid=0; capture exactly once per ack pulse.
REQ-019 States: RX (collect bytes), EXEC (compute), TX (send result, only with UART_RESULT_TX_EN), back to RX.
REQ-020 In EXEC/TX, ack stays 0 and valid is ignored; busy=1.
REQ-021 Internal 32-bit register named ComputeResult holds the last result; it is hierarchically visible and updated only when EXEC completes.
REQ-022 Commands (ASCII): 'm' MUL low 32; 'H' MULH signed x signed high 32; 'h' MULHU unsigned high 32; 'd' DIV signed; 'D' DIVU; 'r' REM signed, sign of dividend; 'M' REMU; 'a' ADD; 's' SUB op1-op2.
REQ-023 Divide by zero: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> op1.
REQ-024 Signed overflow 0x80000000 / 0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
REQ-025 Unknown command: ComputeResult <= 0 and error=1; any valid command clears error.
REQ-026 EXEC latency at most 40 cycles from the ack of byte 9 to the ComputeResult update; add/sub/mul may finish in 1 cycle.
REQ-027 When TIMEOUT_CYCLES>0 and byte_count!=0, that many cycles without a capture resets byte_count to 0; the partial packet is dropped.

Reset
REQ-028 RESET: state=RX, byte_count=0, ComputeResult=0, error=0, busy=0, ack=0, UART_TX_valid=0, UART_TX=0, LED_PC=0, and any division in progress is aborted; reset mid-packet discards the packet.

Configuration
REQ-029 Macro UART_RESULT_TX_EN defined: after EXEC, send ComputeResult as 4 bytes MSB first; each byte is held with valid=1 until a cycle with ready=1, then advances.
REQ-030 Macro UART_RESULT_TX_EN undefined: no TX state, UART_TX_valid=0, UART_TX=0.

Structure
REQ-031 Shared package wrapper_pkg holds the command byte constants, the state enum and the packet length (9).
REQ-032 One sub-module, div_unit: 32-iteration restoring unsigned divider with start/done, sign fix-up in the wrapper.

Verification
REQ-033 'd',14,2 -> 0x00000007; 'D',0x80000000,2 -> 0x40000000.
REQ-034 'r',0xFFFFFFF2,3 -> 0xFFFFFFFE; 'r',14,0xFFFFFFFD -> 2; 'M',0xFFFFFFF2,5 -> 2.
REQ-035 'm',6,7 -> 42; 'H',0x40000000,4 -> 1; 'h',0x80000000,2 -> 1; 'H',0xFFFFFFFF,0xFFFFFFFF -> 0.
REQ-036 'd',5,0 -> 0xFFFFFFFF; 'M',5,0 -> 5; 'd',0x80000000,0xFFFFFFFF -> 0x80000000; 'x',1,1 -> 0 with error=1.
REQ-037 RESET after byte 4 then a full 'a',1,2 packet -> 3; with valid held high, ack stays high and byte_count rises by exactly 1.
REQ-038 With UART_RESULT_TX_EN and ready toggling, 'm',6,7 -> TX bytes 00,00,00,2A in that order, each accepted exactly once.

Source files
------------

// File: rtl/wrapper_pkg.sv
// Shared constants for the UART compute wrapper: command bytes, packet length, FSM states.
package wrapper_pkg;

  localparam logic [7:0] CMD_MUL   = 8'h6d;  // 'm'
  localparam logic [7:0] CMD_MULH  = 8'h48;  // 'H'
  localparam logic [7:0] CMD_MULHU = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DIV   = 8'h64;  // 'd'
  localparam logic [7:0] CMD_DIVU  = 8'h44;  // 'D'
  localparam logic [7:0] CMD_REM   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_REMU  = 8'h4d;  // 'M'
  localparam logic [7:0] CMD_ADD   = 8'h61;  // 'a'
  localparam logic [7:0] CMD_SUB   = 8'h73;  // 's'

  localparam int PKT_LEN = 9;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_EXEC = 2'd1,
    ST_TX   = 2'd2
  } state_t;

  function automatic logic is_div_cmd(input logic [7:0] cmd);
    return (cmd == CMD_DIV) || (cmd == CMD_DIVU) || (cmd == CMD_REM) || (cmd == CMD_REMU);
  endfunction

endpackage

// File: rtl/wrapper_div_unit.sv
// div_unit: 32-iteration restoring unsigned divider; i_start loads operands, o_done pulses once.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_dvs;
  logic [4:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  logic [32:0] w_sh;
  logic [32:0] w_diff;

  // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
  assign w_sh   = {r_r, r_q[31]};
  assign w_diff = w_sh - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_r    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_q   <= i_dividend;
        r_r   <= '0;
        r_dvs <= i_divisor;
        r_cnt <= 5'd31;
        r_run <= 1'b1;
      end else if (r_run) begin
        if (!w_diff[32]) begin
          r_r <= w_diff[31:0];
          r_q <= {r_q[30:0], 1'b1};
        end else begin
          r_r <= w_sh[31:0];
          r_q <= {r_q[30:0], 1'b0};
        end
        if (r_cnt == 5'd0) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 5'd1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_q;
  assign o_rem  = r_r;

endmodule

// File: rtl/wrapper.sv
// UART packet compute engine: 9-byte command packets in, 32-bit result out.
// Define UART_RESULT_TX_EN to stream the result back as 4 bytes, MSB first.
module wrapper
  import wrapper_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] DIP,
  input  logic [2:0]  PB,
  input  logic [7:0]  UART_RX,
  input  logic        UART_RX_valid,
  output logic        UART_RX_ack,
  output logic [7:0]  UART_TX,
  output logic        UART_TX_valid,
  input  logic        UART_TX_ready,
  output logic [7:0]  LED_OUT,
  output logic [6:0]  LED_PC,
  output logic [31:0] SEVENSEGHEX,
  output logic        OLED_Write,
  output logic [6:0]  OLED_Col,
  output logic [5:0]  OLED_Row,
  output logic [23:0] OLED_Data,
  input  logic [31:0] ACCEL_Data,
  input  logic        ACCEL_DReady
);

  localparam logic [3:0] PKT_LEN_C = 4'(PKT_LEN);
`ifdef UART_RESULT_TX_EN
  localparam state_t ST_AFTER_EXEC = ST_TX;
`else
  localparam state_t ST_AFTER_EXEC = ST_RX;
`endif

  state_t      r_state;
  logic [3:0]  r_byte_cnt;
  logic [7:0]  r_cmd;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] ComputeResult;
  logic        r_error;
  logic        r_ack;
  logic        r_div_run;
  logic [31:0] r_idle;
  logic [1:0]  r_tx_idx;

  logic        w_capture;
  logic        w_busy;
  logic [63:0] w_prod_ss;
  logic [63:0] w_prod_uu;
  logic [31:0] w_fast;
  logic        w_known;
  logic        w_use_div;
  logic        w_signed;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_div_done;
  logic        w_div_start;
  logic [31:0] w_div_res;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;
  logic        w_unused;

  assign w_busy    = (r_state != ST_RX);
  assign w_capture = (r_state == ST_RX) && UART_RX_valid && !r_ack && (r_byte_cnt < PKT_LEN_C);

  assign w_prod_ss = {{32{r_op1[31]}}, r_op1} * {{32{r_op2[31]}}, r_op2};
  assign w_prod_uu = {32'b0, r_op1} * {32'b0, r_op2};

  always_comb begin
    w_fast  = '0;
    w_known = 1'b1;
    case (r_cmd)
      CMD_MUL:            w_fast = w_prod_uu[31:0];
      CMD_MULH:           w_fast = w_prod_ss[63:32];
      CMD_MULHU:          w_fast = w_prod_uu[63:32];
      CMD_ADD:            w_fast = r_op1 + r_op2;
      CMD_SUB:            w_fast = r_op1 - r_op2;
      CMD_DIV, CMD_DIVU:  w_fast = '1;
      CMD_REM, CMD_REMU:  w_fast = r_op1;
      default:            w_known = 1'b0;
    endcase
  end

  // Divide by zero never reaches the divider; the fast path supplies its fixed result.
  assign w_use_div   = is_div_cmd(r_cmd) && (r_op2 != 32'd0);
  assign w_signed    = (r_cmd == CMD_DIV) || (r_cmd == CMD_REM);
  assign w_dvd       = (w_signed && r_op1[31]) ? -r_op1 : r_op1;
  assign w_dvs       = (w_signed && r_op2[31]) ? -r_op2 : r_op2;
  assign w_div_start = (r_state == ST_EXEC) && w_use_div && !r_div_run;
  assign w_q_fix     = (w_signed && (r_op1[31] ^ r_op2[31])) ? -w_quot : w_quot;
  assign w_r_fix     = (w_signed && r_op1[31]) ? -w_rem : w_rem;
  assign w_div_res   = ((r_cmd == CMD_DIV) || (r_cmd == CMD_DIVU)) ? w_q_fix : w_r_fix;

  div_unit u_div (
    .clk        (CLK),
    .rst        (RESET),
    .i_start    (w_div_start),
    .i_dividend (w_dvd),
    .i_divisor  (w_dvs),
    .o_done     (w_div_done),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= ST_RX;
      r_byte_cnt    <= '0;
      r_cmd         <= '0;
      r_op1         <= '0;
      r_op2         <= '0;
      ComputeResult <= '0;
      r_error       <= 1'b0;
      r_ack         <= 1'b0;
      r_div_run     <= 1'b0;
      r_idle        <= '0;
      r_tx_idx      <= '0;
    end else begin
      case (r_state)
        ST_RX: begin
          if (w_capture) begin
            r_ack      <= 1'b1;
            r_byte_cnt <= r_byte_cnt + 4'd1;
            r_idle     <= 32'(TIMEOUT_CYCLES - 1);
            if (r_byte_cnt == 4'd0)
              r_cmd <= UART_RX;
            else if (r_byte_cnt < 4'd5)
              r_op1 <= {r_op1[23:0], UART_RX};
            else
              r_op2 <= {r_op2[23:0], UART_RX};
          end else begin
            // Execution waits for the last byte's handshake to close so ack is low while busy.
            if (r_ack && !UART_RX_valid) begin
              r_ack <= 1'b0;
              if (r_byte_cnt == PKT_LEN_C)
                r_state <= ST_EXEC;
            end
            if ((TIMEOUT_CYCLES > 0) && (r_byte_cnt != 4'd0) && (r_byte_cnt != PKT_LEN_C)) begin
              if (r_idle == 32'd0)
                r_byte_cnt <= '0;
              else
                r_idle <= r_idle - 32'd1;
            end
          end
        end
        ST_EXEC: begin
          r_ack <= 1'b0;
          if (w_use_div) begin
            if (!r_div_run) begin
              r_div_run <= 1'b1;
            end else if (w_div_done) begin
              ComputeResult <= w_div_res;
              r_error       <= 1'b0;
              r_div_run     <= 1'b0;
              r_byte_cnt    <= '0;
              r_tx_idx      <= '0;
              r_state       <= ST_AFTER_EXEC;
            end
          end else begin
            ComputeResult <= w_fast;
            r_error       <= !w_known;
            r_byte_cnt    <= '0;
            r_tx_idx      <= '0;
            r_state       <= ST_AFTER_EXEC;
          end
        end
        ST_TX: begin
          if (UART_TX_ready) begin
            r_tx_idx <= r_tx_idx + 2'd1;
            if (r_tx_idx == 2'd3)
              r_state <= ST_RX;
          end
        end
        default: r_state <= ST_RX;
      endcase
    end
  end

`ifdef UART_RESULT_TX_EN
  logic [7:0] w_tx_byte;
  always_comb begin
    w_tx_byte = '0;
    case (r_tx_idx)
      2'd0:    w_tx_byte = ComputeResult[31:24];
      2'd1:    w_tx_byte = ComputeResult[23:16];
      2'd2:    w_tx_byte = ComputeResult[15:8];
      default: w_tx_byte = ComputeResult[7:0];
    endcase
  end
  assign UART_TX_valid = (r_state == ST_TX);
  assign UART_TX       = (r_state == ST_TX) ? w_tx_byte : 8'h00;
`else
  assign UART_TX_valid = 1'b0;
  assign UART_TX       = 8'h00;
`endif

  assign UART_RX_ack = r_ack;
  assign LED_OUT     = {w_busy, r_error, 2'b00, r_byte_cnt};
  assign LED_PC      = r_cmd[6:0];
  assign SEVENSEGHEX = ComputeResult;
  assign OLED_Write  = 1'b0;
  assign OLED_Col    = '0;
  assign OLED_Row    = '0;
  assign OLED_Data   = '0;

  assign w_unused = ^{DIP, PB, ACCEL_Data, ACCEL_DReady, w_prod_ss[31:0]};

endmodule

// File: tb/tb_wrapper.sv
// Directed self-checking bench for wrapper; exercises UART_RESULT_TX_EN path when that macro is defined.
module tb_wrapper;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] DIP;
  logic [2:0]  PB;
  logic [7:0]  UART_RX;
  logic        UART_RX_valid;
  logic        UART_RX_ack;
  logic [7:0]  UART_TX;
  logic        UART_TX_valid;
  logic        UART_TX_ready;
  logic [7:0]  LED_OUT;
  logic [6:0]  LED_PC;
  logic [31:0] SEVENSEGHEX;
  logic        OLED_Write;
  logic [6:0]  OLED_Col;
  logic [5:0]  OLED_Row;
  logic [23:0] OLED_Data;
  logic [31:0] ACCEL_Data;
  logic        ACCEL_DReady;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  wrapper dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .DIP           (DIP),
    .PB            (PB),
    .UART_RX       (UART_RX),
    .UART_RX_valid (UART_RX_valid),
    .UART_RX_ack   (UART_RX_ack),
    .UART_TX       (UART_TX),
    .UART_TX_valid (UART_TX_valid),
    .UART_TX_ready (UART_TX_ready),
    .LED_OUT       (LED_OUT),
    .LED_PC        (LED_PC),
    .SEVENSEGHEX   (SEVENSEGHEX),
    .OLED_Write    (OLED_Write),
    .OLED_Col      (OLED_Col),
    .OLED_Row      (OLED_Row),
    .OLED_Data     (OLED_Data),
    .ACCEL_Data    (ACCEL_Data),
    .ACCEL_DReady  (ACCEL_DReady)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input logic level);
    int n = 0;
    while ((UART_RX_ack !== level) && (n < 50)) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) chk("ack_wait", {31'b0, UART_RX_ack}, {31'b0, level});
  endtask

  task automatic send_byte(input logic [7:0] b);
    UART_RX       = b;
    UART_RX_valid = 1'b1;
    @(negedge CLK);
    wait_ack(1'b1);
    UART_RX_valid = 1'b0;
    @(negedge CLK);
    wait_ack(1'b0);
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(b[8*i +: 8]);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (LED_OUT[7] && (n < 100)) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    send_pkt(cmd, a, b);
    wait_idle(n);
    chk(tag, SEVENSEGHEX, exp);
    chk({tag, "_lat"}, (n <= 40) ? 32'd1 : 32'd0, 32'd1);
    chk({tag, "_err"}, {31'b0, LED_OUT[6]}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [7:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[20];
  int   n_idle;
  logic [3:0] cnt_before;

  initial begin
    vecs[0]  = '{"div_14_2",      8'h64, 32'd14,        32'd2,         32'h00000007};
    vecs[1]  = '{"divu_big",      8'h44, 32'h80000000,  32'd2,         32'h40000000};
    vecs[2]  = '{"rem_neg_dvd",   8'h72, 32'hFFFFFFF2,  32'd3,         32'hFFFFFFFE};
    vecs[3]  = '{"rem_neg_dvs",   8'h72, 32'd14,        32'hFFFFFFFD,  32'h00000002};
    vecs[4]  = '{"remu",          8'h4d, 32'hFFFFFFF2,  32'd5,         32'h00000002};
    vecs[5]  = '{"mul_6_7",       8'h6d, 32'd6,         32'd7,         32'd42};
    vecs[6]  = '{"mulh_pos",      8'h48, 32'h40000000,  32'd4,         32'h00000001};
    vecs[7]  = '{"mulhu",         8'h68, 32'h80000000,  32'd2,         32'h00000001};
    vecs[8]  = '{"mulh_m1_m1",    8'h48, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000};
    vecs[9]  = '{"div_by_zero",   8'h64, 32'd5,         32'd0,         32'hFFFFFFFF};
    vecs[10] = '{"remu_by_zero",  8'h4d, 32'd5,         32'd0,         32'h00000005};
    vecs[11] = '{"div_overflow",  8'h64, 32'h80000000,  32'hFFFFFFFF,  32'h80000000};
    vecs[12] = '{"rem_overflow",  8'h72, 32'h80000000,  32'hFFFFFFFF,  32'h00000000};
    vecs[13] = '{"divu_by_zero",  8'h44, 32'd5,         32'd0,         32'hFFFFFFFF};
    vecs[14] = '{"rem_by_zero",   8'h72, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB};
    vecs[15] = '{"add_wrap",      8'h61, 32'hFFFFFFFF,  32'd2,         32'h00000001};
    vecs[16] = '{"sub_neg",       8'h73, 32'd5,         32'd7,         32'hFFFFFFFE};
    vecs[17] = '{"div_neg_trunc", 8'h64, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD};
    vecs[18] = '{"mul_low_m1",    8'h6d, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001};
    vecs[19] = '{"mulhu_max",     8'h68, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE};

    RESET         = 1'b1;
    DIP           = 16'hA5A5;
    PB            = 3'b101;
    UART_RX       = 8'h00;
    UART_RX_valid = 1'b0;
    UART_TX_ready = 1'b1;
    ACCEL_Data    = 32'h12345678;
    ACCEL_DReady  = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    chk("rst_led",   {24'b0, LED_OUT}, 32'd0);
    chk("rst_pc",    {25'b0, LED_PC}, 32'd0);
    chk("rst_seg",   SEVENSEGHEX, 32'd0);
    chk("rst_ack",   {31'b0, UART_RX_ack}, 32'd0);
    chk("rst_txv",   {31'b0, UART_TX_valid}, 32'd0);
    chk("rst_tx",    {24'b0, UART_TX}, 32'd0);
    chk("oled_data", {8'b0, OLED_Data}, 32'd0);

    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].exp);
    chk("led_pc_last", {25'b0, LED_PC}, 32'h68);

    send_pkt(8'h78, 32'd1, 32'd1);
    wait_idle(n_idle);
    chk("unknown_res", dut.ComputeResult, 32'd0);
    chk("unknown_err", {31'b0, LED_OUT[6]}, 32'd1);
    run_op("err_clear_add", 8'h61, 32'd1, 32'd1, 32'd2);

    // Reset in the middle of a packet drops the collected bytes.
    send_byte(8'h61);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("mid_cnt4", {28'b0, LED_OUT[3:0]}, 32'd4);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("mid_rst_cnt", {28'b0, LED_OUT[3:0]}, 32'd0);
    chk("mid_rst_res", SEVENSEGHEX, 32'd0);

    cnt_before    = LED_OUT[3:0];
    UART_RX       = 8'h61;
    UART_RX_valid = 1'b1;
    @(negedge CLK);
    wait_ack(1'b1);
    repeat (6) @(negedge CLK);
    chk("hold_ack", {31'b0, UART_RX_ack}, 32'd1);
    chk("hold_cnt", {28'b0, LED_OUT[3:0]}, {28'b0, cnt_before + 4'd1});
    UART_RX_valid = 1'b0;
    @(negedge CLK);
    wait_ack(1'b0);
    for (int i = 3; i >= 0; i--) send_byte(8'((32'd1 >> (8*i)) & 32'hFF));
    for (int i = 3; i >= 0; i--) send_byte(8'((32'd2 >> (8*i)) & 32'hFF));
    wait_idle(n_idle);
    chk("after_rst_add", SEVENSEGHEX, 32'd3);

    // Reset during a running division must abort it and leave the result cleared.
    send_pkt(8'h64, 32'd100, 32'd7);
    repeat (5) @(negedge CLK);
    chk("div_running_busy", {31'b0, LED_OUT[7]}, 32'd1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    repeat (40) @(negedge CLK);
    chk("div_abort_res", SEVENSEGHEX, 32'd0);
    chk("div_abort_busy", {31'b0, LED_OUT[7]}, 32'd0);
    run_op("post_abort_div", 8'h64, 32'd100, 32'd7, 32'd14);

`ifdef UART_RESULT_TX_EN
    begin
      logic [7:0] got_bytes[8];
      int         n_got;
      int         k;
      send_pkt(8'h6d, 32'd6, 32'd7);
      n_got = 0;
      k     = 0;
      while ((LED_OUT[7] || k < 2) && (k < 300)) begin
        UART_TX_ready = k[0];
        if (UART_TX_valid && UART_TX_ready) begin
          if (n_got < 8) got_bytes[n_got] = UART_TX;
          n_got++;
        end
        @(negedge CLK);
        k++;
      end
      UART_TX_ready = 1'b1;
      chk("tx_count", n_got, 32'd4);
      chk("tx_b0", {24'b0, got_bytes[0]}, 32'h00);
      chk("tx_b1", {24'b0, got_bytes[1]}, 32'h00);
      chk("tx_b2", {24'b0, got_bytes[2]}, 32'h00);
      chk("tx_b3", {24'b0, got_bytes[3]}, 32'h2A);
      chk("tx_idle_valid", {31'b0, UART_TX_valid}, 32'd0);
    end
`else
    chk("tx_off_valid", {31'b0, UART_TX_valid}, 32'd0);
    chk("tx_off_data", {24'b0, UART_TX}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
